line_buffer: RTL
================

LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have parameter WINDOW_HEIGHT, default 3, pixels per output column; legal range 2..8.
REQ-005 SHALL have port clk, input, 1, the only clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, raster-order pixel stream.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 SHALL have port out_data, output, DATA_WIDTH*WINDOW_HEIGHT, vertical pixel column for the downstream horizontal kernel shift register.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.

Function
REQ-013 SHALL count an input transfer (accept) only on a cycle where in_valid and in_ready are both 1.
REQ-014 SHALL hold WINDOW_HEIGHT-1 row delay lines, each IMAGE_WIDTH deep, cascaded; line 0 is fed by in_data and line k by line k-1's output, and each line advances only on an accept.
REQ-015 SHALL drive out_data as {in_data, line0_out, ..., lineN_out}; the MSB slice is the current pixel, the LSB slice is the oldest row, and every slice is from the same column.
REQ-016 SHALL implement each delay line as a circular buffer addressed by the column counter, with combinational read-before-write at the same address, so the read data equals the pixel written IMAGE_WIDTH accepts earlier.
REQ-017 SHALL keep col_cnt in 0..IMAGE_WIDTH-1, incrementing per accept and wrapping to 0 after IMAGE_WIDTH-1.
REQ-018 SHALL keep row_cnt in 0..IMAGE_HEIGHT-1, incrementing on a col_cnt wrap and wrapping to 0 after the last pixel of the frame (row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1).
REQ-019 SHALL implement the FSM state S_FILL with in_ready=1 and out_valid=0, accepting rows 0..WINDOW_HEIGHT-2 without producing output.
REQ-020 SHALL transition S_FILL -> S_STREAM on the accept of pixel (row WINDOW_HEIGHT-2, col IMAGE_WIDTH-1).
REQ-021 SHALL implement the FSM state S_STREAM with in_ready=out_ready and out_valid=in_valid; the path is zero-latency and combinational, and one input accept equals one output transfer.
REQ-022 SHALL transition S_STREAM -> S_FILL on the accept of the last pixel of a frame, so that no column mixes rows of two frames.
REQ-023 SHALL NOT accept or change any state while out_ready=0 in S_STREAM; out_data then tracks in_data only.
REQ-024 SHALL handle the simultaneous col wrap, row wrap and state change in a single cycle, without losing a pixel.
REQ-025 SHALL produce exactly (IMAGE_HEIGHT-WINDOW_HEIGHT+1)*IMAGE_WIDTH output transfers per frame.

Reset
REQ-026 SHALL, while rst=0, force in_ready=0, out_valid=0, col_cnt=0, row_cnt=0 and state S_FILL.
REQ-027 SHALL NOT clear delay-line contents on reset, because S_FILL overwrites them before any use.
REQ-028 SHALL, on a reset mid-frame, discard the partial frame; the first accept after reset is taken as pixel (0,0).

Structure
REQ-029 SHALL take the FSM state encodings (S_FILL, S_STREAM) from the shared HOG header, which the kernel-stage modules also use.
REQ-030 SHALL instantiate one sub-module, row_delay (parameters DATA_WIDTH and IMAGE_WIDTH; ports clk, wr_en, addr, din, dout), WINDOW_HEIGHT-1 times through a generate loop.

Verification
REQ-031 SHALL be verified with IMAGE_WIDTH=4, IMAGE_HEIGHT=4, WINDOW_HEIGHT=3 and pixel value = row*16+col.
REQ-032 SHALL pass this scenario: continuous valid with out_ready=1 -> out_valid first asserts on pixel (2,0) with out_data={0x20,0x10,0x00}, and 8 transfers follow in total.
REQ-033 SHALL pass this scenario: out_ready=0 for 3 cycles during S_STREAM at (2,1) -> in_ready=0 and no counter advance; on release, out_data={0x21,0x11,0x01} is transferred once.
REQ-034 SHALL pass this scenario: random in_valid gaps -> the output column sequence is identical to the gap-free run.
REQ-035 SHALL pass this scenario: two back-to-back frames (frame 2 = frame 1 + 0x80) -> no output during frame 2 rows 0-1, and the first frame-2 output is {0xA0,0x90,0x80}.
REQ-036 SHALL pass this scenario: rst=0 asserted at (3,2) for 1 cycle -> out_valid=0 and in_ready=0 that cycle; the next 8 accepts produce no output; output then resumes at the third row after reset.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared HOG definitions: FSM state encodings and counter sizing helper,
// used by the line buffer and the kernel-stage modules.
package line_buffer_pkg;

  // Fill: priming the delay lines; Stream: one output column per accept.
  typedef enum logic {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } lb_state_e;

  // Width of a counter covering 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_row_delay.sv
// One row delay line: a circular buffer indexed by the column counter.
// The read is combinational, so at a given address the old pixel comes out
// on the same cycle the new one is written (read-before-write).
module row_delay
  import line_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMAGE_WIDTH = 640
) (
  input  logic                                 clk,
  input  logic                                 wr_en,
  input  logic [cnt_width(IMAGE_WIDTH)-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic [DATA_WIDTH-1:0]                dout
);

  logic [DATA_WIDTH-1:0] mem [IMAGE_WIDTH];

  assign dout = mem[addr];

  // Storage is never reset; the fill phase overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/line_buffer.sv
// Line buffer: turns a raster pixel stream into vertical columns of
// WINDOW_HEIGHT pixels (current pixel in the MSB slice, oldest row in the LSB
// slice) for a downstream horizontal kernel shift register.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned WINDOW_HEIGHT = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [DATA_WIDTH*WINDOW_HEIGHT-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int unsigned NumLines = WINDOW_HEIGHT - 1;
  localparam int unsigned CW       = cnt_width(IMAGE_WIDTH);
  localparam int unsigned RW       = cnt_width(IMAGE_HEIGHT);

  lb_state_e       state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            accept;
  logic            col_last;
  logic            row_last;

  logic [DATA_WIDTH-1:0] line_din  [NumLines];
  logic [DATA_WIDTH-1:0] line_dout [NumLines];

  assign col_last = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_last = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign accept   = in_valid & in_ready;

  // Handshake: free-running intake while filling, pass-through while streaming.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      case (state_q)
        S_FILL: begin
          in_ready = 1'b1;
        end
        S_STREAM: begin
          in_ready  = out_ready;
          out_valid = in_valid;
        end
        default: ;
      endcase
    end
  end

  // Position counters and FSM; all advance only on an accepted pixel, so the
  // column wrap, row wrap and state change of a frame end land in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= S_FILL;
    end else if (accept) begin
      col_q <= col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_q <= row_last ? '0 : row_q + 1'b1;
      end
      case (state_q)
        S_FILL: begin
          if (col_last && (row_q == RW'(WINDOW_HEIGHT - 2))) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          // Back to fill at frame end so no column mixes two frames.
          if (col_last && row_last) begin
            state_q <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  // Cascaded delay lines; line k feeds line k+1 and lands in slice NumLines-1-k.
  for (genvar k = 0; k < NumLines; k++) begin : g_line
    if (k == 0) begin : g_first
      assign line_din[k] = in_data;
    end else begin : g_next
      assign line_din[k] = line_dout[k-1];
    end

    row_delay #(
      .DATA_WIDTH  (DATA_WIDTH),
      .IMAGE_WIDTH (IMAGE_WIDTH)
    ) u_row_delay (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col_q),
      .din   (line_din[k]),
      .dout  (line_dout[k])
    );

    assign out_data[DATA_WIDTH*(NumLines-1-k) +: DATA_WIDTH] = line_dout[k];
  end

  assign out_data[DATA_WIDTH*NumLines +: DATA_WIDTH] = in_data;

endmodule
